// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer sitting between a read-only instruction
// memory (one-cycle read latency) and the decode stage.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous active-high reset
//   stall          decode not ready; displayed instruction is held
//   branch_taken   single-cycle redirect request (wins over stall)
//   branch_target  redirect byte address; low two bits are dropped
//   mem_addr       address to instr_mem (combinational)
//   mem_instr      instr_mem data for the previous cycle's mem_addr
//   instr_out      instruction to decode, zero when not valid
//   pc_out         byte address of instr_out
//   instr_valid    instr_out/pc_out carry a valid instruction
//   align_err      one-cycle registered pulse after a misaligned redirect
//   instr_count    number of instructions consumed by decode
module fetch_ctrl #(
  parameter int unsigned WordW  = 32,
  parameter int unsigned InstrW = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [WordW-1:0]  branch_target,
  output logic [WordW-1:0]  mem_addr,
  input  logic [InstrW-1:0] mem_instr,
  output logic [InstrW-1:0] instr_out,
  output logic [WordW-1:0]  pc_out,
  output logic              instr_valid,
  output logic              align_err,
  output logic [31:0]       instr_count
);

  typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

  localparam logic [WordW-1:0] Four = WordW'(4);

  state_e           state_q;
  logic [WordW-1:0] fetch_pc_q;  // next new address to fetch
  logic [WordW-1:0] resp_pc_q;   // address whose data is on mem_instr now
  logic             align_q;
  logic [31:0]      count_q;
  logic [WordW-1:0] target_al;

  assign target_al = {branch_target[WordW-1:2], 2'b00};

  // Address and valid decode. A redirect issues the target immediately and
  // suppresses the instruction on display, giving a single bubble.
  always_comb begin
    mem_addr    = '0;
    instr_valid = 1'b0;
    if (!reset) begin
      if (branch_taken) begin
        mem_addr = target_al;
      end else if (state_q != StIdle) begin
        instr_valid = 1'b1;
        // On a stall re-read the displayed word so mem_instr keeps showing it.
        mem_addr    = stall ? resp_pc_q : fetch_pc_q;
      end
    end
  end

  assign instr_out   = instr_valid ? mem_instr : '0;
  assign pc_out      = reset ? '0 : resp_pc_q;
  assign align_err   = align_q & ~reset;
  assign instr_count = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      fetch_pc_q <= '0;
      resp_pc_q  <= '0;
      align_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      align_q <= branch_taken && (branch_target[1:0] != 2'b00);
      if (branch_taken) begin
        resp_pc_q  <= target_al;
        fetch_pc_q <= target_al + Four;
        state_q    <= StRun;
      end else begin
        case (state_q)
          StIdle: begin
            resp_pc_q  <= '0;
            fetch_pc_q <= Four;
            state_q    <= StRun;
          end
          StRun, StHold: begin
            if (stall) begin
              state_q <= StHold;
            end else begin
              resp_pc_q  <= fetch_pc_q;
              fetch_pc_q <= fetch_pc_q + Four;
              state_q    <= StRun;
              count_q    <= count_q + 32'd1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] mem_addr;
  logic [31:0] mem_instr;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        align_err;
  logic [31:0] instr_count;

  int n_vec = 0;
  int n_err = 0;

  fetch_ctrl #(
    .WordW (32),
    .InstrW(32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .mem_addr     (mem_addr),
    .mem_instr    (mem_instr),
    .instr_out    (instr_out),
    .pc_out       (pc_out),
    .instr_valid  (instr_valid),
    .align_err    (align_err),
    .instr_count  (instr_count)
  );

  // Clock starts high so the first event is a falling edge (sample point).
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  // Injective address-to-word mapping standing in for the instruction ROM.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16] ^ ~a[15:0]};
  endfunction

  initial mem_instr = '0;
  always @(posedge clk) mem_instr <= rom(mem_addr);

  // Reference model: whether an instruction is on display, its address, the
  // consumed-instruction count and the pending misalignment flag. The next new
  // fetch is always the displayed address plus four.
  bit          m_started = 1'b0;
  logic [31:0] m_pc      = '0;
  logic [31:0] m_count   = '0;
  bit          m_align   = 1'b0;

  logic [31:0] e_addr, e_pc, e_instr;
  bit          e_valid, e_align;

  task automatic drive(input bit r, input bit s, input bit b, input logic [31:0] t);
    reset = r; stall = s; branch_taken = b; branch_target = t;
    if (r) begin
      e_addr = '0; e_valid = 1'b0; e_pc = '0; e_instr = '0; e_align = 1'b0;
    end else begin
      e_valid = m_started && !b;
      if (b)               e_addr = {t[31:2], 2'b00};
      else if (!m_started) e_addr = '0;
      else if (s)          e_addr = m_pc;
      else                 e_addr = m_pc + 32'd4;
      e_pc    = m_pc;
      e_instr = e_valid ? rom(m_pc) : '0;
      e_align = m_align;
    end
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_started = 1'b0; m_pc = '0; m_count = '0; m_align = 1'b0;
    end else begin
      m_align = branch_taken && (branch_target[1:0] != 2'b00);
      if (branch_taken) begin
        m_pc = {branch_target[31:2], 2'b00}; m_started = 1'b1;
      end else if (!m_started) begin
        m_pc = '0; m_started = 1'b1;
      end else if (!stall) begin
        m_pc = m_pc + 32'd4; m_count = m_count + 32'd1;
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    drive(1'b1, 1'b0, 1'b0, '0); tick();
    drive(1'b1, 1'b0, 1'b0, '0); tick();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b1, 32'h0000_0123);
      n_vec++; if (mem_addr !== 32'd0) begin n_err++;
        $display("FAIL reset_addr: got %h want 0", mem_addr); end
      n_vec++; if (instr_valid !== 1'b0 || instr_out !== 32'd0 || pc_out !== 32'd0) begin
        n_err++; $display("FAIL reset_outs: valid %b instr %h pc %h want 0", instr_valid,
                          instr_out, pc_out); end
      n_vec++; if (align_err !== 1'b0) begin n_err++;
        $display("FAIL reset_align: got %b want 0", align_err); end
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, '0);
    n_vec++; if (instr_count !== 32'd0) begin n_err++;
      $display("FAIL reset_count: got %0d want 0", instr_count); end
    tick();
  endtask

  task automatic test_sequential();
    logic [31:0] addrs [4] = '{32'd0, 32'd4, 32'd8, 32'd12};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, '0);
      n_vec++; if (mem_addr !== addrs[i]) begin n_err++;
        $display("FAIL seq_addr[%0d]: got %h want %h", i, mem_addr, addrs[i]); end
      n_vec++; if (instr_valid !== (i > 0)) begin n_err++;
        $display("FAIL seq_valid[%0d]: got %b want %b", i, instr_valid, i > 0); end
      if (i > 0) begin
        n_vec++; if (pc_out !== 32'((i - 1) * 4) || instr_out !== rom(32'((i - 1) * 4))) begin
          n_err++; $display("FAIL seq_pc[%0d]: got %h/%h want %h", i, pc_out, instr_out,
                            (i - 1) * 4); end
      end
      tick();
    end
    drive(1'b0, 1'b1, 1'b0, '0);
    n_vec++; if (instr_count !== 32'd3) begin n_err++;
      $display("FAIL seq_count: got %0d want 3", instr_count); end
    tick();
  endtask

  task automatic test_stall();
    apply_reset();
    for (int i = 0; i < 3; i++) begin drive(1'b0, 1'b0, 1'b0, '0); tick(); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, '0);
      n_vec++; if (pc_out !== 32'd8 || mem_addr !== 32'd8 || instr_valid !== 1'b1) begin
        n_err++; $display("FAIL stall_hold[%0d]: pc %h addr %h valid %b want 8/8/1", i, pc_out,
                          mem_addr, instr_valid); end
      n_vec++; if (instr_out !== rom(32'd8)) begin n_err++;
        $display("FAIL stall_instr[%0d]: got %h want %h", i, instr_out, rom(32'd8)); end
      n_vec++; if (instr_count !== 32'd2) begin n_err++;
        $display("FAIL stall_count[%0d]: got %0d want 2", i, instr_count); end
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, '0);
    n_vec++; if (mem_addr !== 32'd12) begin n_err++;
      $display("FAIL stall_release_addr: got %h want c", mem_addr); end
    tick();
    drive(1'b0, 1'b0, 1'b0, '0);
    n_vec++; if (pc_out !== 32'd12 || instr_out !== rom(32'd12) || instr_count !== 32'd3) begin
      n_err++; $display("FAIL stall_release_pc: pc %h count %0d want c/3", pc_out, instr_count);
    end
    tick();
  endtask

  task automatic test_branch();
    apply_reset();
    for (int i = 0; i < 5; i++) begin drive(1'b0, 1'b0, 1'b0, '0); tick(); end
    drive(1'b0, 1'b0, 1'b1, 32'd40);
    n_vec++; if (mem_addr !== 32'd40 || instr_valid !== 1'b0 || instr_out !== 32'd0) begin
      n_err++; $display("FAIL br_issue: addr %h valid %b want 28/0", mem_addr, instr_valid); end
    n_vec++; if (pc_out !== 32'd16 || instr_count !== 32'd4) begin n_err++;
      $display("FAIL br_pre: pc %h count %0d want 10/4", pc_out, instr_count); end
    tick();
    drive(1'b0, 1'b0, 1'b0, '0);
    n_vec++; if (pc_out !== 32'd40 || instr_valid !== 1'b1 || mem_addr !== 32'd44 ||
                 instr_out !== rom(32'd40) || instr_count !== 32'd4) begin
      n_err++; $display("FAIL br_target: pc %h valid %b addr %h count %0d want 28/1/2c/4",
                        pc_out, instr_valid, mem_addr, instr_count); end
    tick();
    drive(1'b0, 1'b1, 1'b1, 32'd32);
    n_vec++; if (mem_addr !== 32'd32 || instr_valid !== 1'b0) begin n_err++;
      $display("FAIL br_stall_issue: addr %h valid %b want 20/0", mem_addr, instr_valid); end
    tick();
    drive(1'b0, 1'b0, 1'b0, '0);
    n_vec++; if (pc_out !== 32'd32 || instr_valid !== 1'b1 || instr_out !== rom(32'd32)) begin
      n_err++; $display("FAIL br_stall_target: pc %h valid %b want 20/1", pc_out, instr_valid);
    end
    tick();
  endtask

  task automatic test_misalign();
    drive(1'b0, 1'b0, 1'b1, 32'h2A);
    n_vec++; if (mem_addr !== 32'h28 || align_err !== 1'b0) begin n_err++;
      $display("FAIL mis_issue: addr %h align %b want 28/0", mem_addr, align_err); end
    tick();
    drive(1'b0, 1'b0, 1'b0, '0);
    n_vec++; if (align_err !== 1'b1 || pc_out !== 32'h28 || instr_valid !== 1'b1) begin
      n_err++; $display("FAIL mis_pulse: align %b pc %h want 1/28", align_err, pc_out); end
    tick();
    drive(1'b0, 1'b0, 1'b0, '0);
    n_vec++; if (align_err !== 1'b0 || pc_out !== 32'h2C) begin n_err++;
      $display("FAIL mis_end: align %b pc %h want 0/2c", align_err, pc_out); end
    tick();
  endtask

  task automatic test_reset_in_hold();
    drive(1'b0, 1'b1, 1'b0, '0); tick();
    drive(1'b0, 1'b1, 1'b0, '0); tick();
    drive(1'b1, 1'b1, 1'b0, '0);
    n_vec++; if (mem_addr !== 32'd0 || instr_valid !== 1'b0 || pc_out !== 32'd0) begin
      n_err++; $display("FAIL rsthold_a: addr %h valid %b pc %h want 0", mem_addr, instr_valid,
                        pc_out); end
    tick();
    drive(1'b1, 1'b1, 1'b1, 32'd100);
    n_vec++; if (mem_addr !== 32'd0 || instr_valid !== 1'b0 || align_err !== 1'b0) begin
      n_err++; $display("FAIL rsthold_b: addr %h valid %b want 0", mem_addr, instr_valid); end
    tick();
    drive(1'b0, 1'b0, 1'b0, '0);
    n_vec++; if (mem_addr !== 32'd0 || instr_valid !== 1'b0 || instr_count !== 32'd0) begin
      n_err++; $display("FAIL rsthold_idle: addr %h valid %b count %0d want 0", mem_addr,
                        instr_valid, instr_count); end
    tick();
    drive(1'b0, 1'b0, 1'b0, '0);
    n_vec++; if (pc_out !== 32'd0 || instr_valid !== 1'b1 || instr_out !== rom(32'd0)) begin
      n_err++; $display("FAIL rsthold_first: pc %h valid %b want 0/1", pc_out, instr_valid); end
    tick();
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC); tick();
    drive(1'b0, 1'b0, 1'b0, '0);
    n_vec++; if (pc_out !== 32'hFFFF_FFFC || mem_addr !== 32'd0) begin n_err++;
      $display("FAIL wrap_addr: pc %h addr %h want fffffffc/0", pc_out, mem_addr); end
    tick();
    drive(1'b0, 1'b0, 1'b0, '0);
    n_vec++; if (pc_out !== 32'd0 || instr_out !== rom(32'd0) || align_err !== 1'b0) begin
      n_err++; $display("FAIL wrap_pc: pc %h align %b want 0/0", pc_out, align_err); end
    tick();
  endtask

  task automatic test_idle_redirect();
    apply_reset();
    drive(1'b0, 1'b0, 1'b1, 32'h100);
    n_vec++; if (mem_addr !== 32'h100 || instr_valid !== 1'b0) begin n_err++;
      $display("FAIL idlebr_issue: addr %h valid %b want 100/0", mem_addr, instr_valid); end
    tick();
    drive(1'b0, 1'b0, 1'b0, '0);
    n_vec++; if (pc_out !== 32'h100 || instr_valid !== 1'b1 || mem_addr !== 32'h104) begin
      n_err++; $display("FAIL idlebr_target: pc %h valid %b addr %h want 100/1/104", pc_out,
                        instr_valid, mem_addr); end
    tick();
  endtask

  task automatic test_random();
    bit          r, s, b;
    logic [31:0] t;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(99) < 3);
      s = ($urandom_range(99) < 30);
      b = ($urandom_range(99) < 15);
      t = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      drive(r, s, b, t);
      n_vec++; if (mem_addr !== e_addr) begin n_err++;
        $display("FAIL rnd_addr[%0d]: got %h want %h", i, mem_addr, e_addr); end
      n_vec++; if (instr_valid !== e_valid || instr_out !== e_instr) begin n_err++;
        $display("FAIL rnd_instr[%0d]: got %b/%h want %b/%h", i, instr_valid, instr_out,
                 e_valid, e_instr); end
      if (e_valid || r) begin
        n_vec++; if (pc_out !== e_pc) begin n_err++;
          $display("FAIL rnd_pc[%0d]: got %h want %h", i, pc_out, e_pc); end
      end
      n_vec++; if (align_err !== e_align) begin n_err++;
        $display("FAIL rnd_align[%0d]: got %b want %b", i, align_err, e_align); end
      n_vec++; if (instr_count !== m_count) begin n_err++;
        $display("FAIL rnd_count[%0d]: got %0d want %0d", i, instr_count, m_count); end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_misalign();
    test_reset_in_hold();
    test_wrap();
    test_idle_redirect();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 clk  input  1  rising-edge clock, the only clock.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 stall  input  1  decode not ready; the presented instruction is not consumed this cycle.
REQ-004 branch_taken  input  1  single-cycle redirect request.
REQ-005 branch_target  input  `WORD  redirect byte address, valid when branch_taken=1.
REQ-006 mem_addr  output  `WORD  address to instr_mem; combinational from state and inputs.
REQ-007 mem_instr  input  `INSTR_LEN  instr_mem read data; returns the word at the mem_addr of the previous cycle.
REQ-008 instr_out  output  `INSTR_LEN  instruction to decode; mem_instr when instr_valid=1, else 0.
REQ-009 pc_out  output  `WORD  byte address of instr_out.
REQ-010 instr_valid  output  1  instr_out/pc_out hold a valid fetched instruction.
REQ-011 align_err  output  1  one-cycle pulse, registered: last accepted branch_target had bits [1:0] != 0.
REQ-012 instr_count  output  32  count of instructions consumed by decode.

Function
REQ-013 Internal registers: state {IDLE, RUN, HOLD}; fetch_pc (address of next new fetch); resp_pc (address whose data is on mem_instr this cycle).
REQ-014 IDLE: mem_addr=0, instr_valid=0; next state RUN, resp_pc<=0, fetch_pc<=4.
REQ-015 RUN/HOLD: instr_valid=1, pc_out=resp_pc, unless overridden by REQ-018.
REQ-016 Advance (RUN or HOLD, stall=0, branch_taken=0): mem_addr=fetch_pc; resp_pc<=fetch_pc; fetch_pc<=fetch_pc+4; next state RUN; instr_count<=instr_count+1.
REQ-017 Stall (RUN or HOLD, stall=1, branch_taken=0): mem_addr=resp_pc (re-read of the displayed word, relying on the read-only memory); resp_pc and fetch_pc unchanged; next state HOLD; instr_count unchanged.
REQ-018 Redirect (any non-reset state, branch_taken=1): branch_taken has priority over stall.
  - Same cycle: mem_addr={branch_target[`WORD-1:2],2'b00}; instr_valid=0; instr_count unchanged.
  - Next edge: resp_pc<=aligned target; fetch_pc<=aligned target+4; next state RUN.
  - Result: one bubble; the target instruction is valid on the next cycle.
REQ-019 align_err<=1 for one cycle after a redirect with branch_target[1:0]!=0, else 0.
REQ-020 Address arithmetic is modulo 2^`WORD; fetch_pc at 2^`WORD-4 wraps to 0 with no flag.
REQ-021 instr_count wraps from 2^32-1 to 0.
REQ-022 Redirect in IDLE: the target overrides address 0, REQ-018 applies, and instr_valid stays 0.
REQ-023 Latency: a fetch presented on mem_addr in cycle N is on instr_out with instr_valid=1 in cycle N+1.

Reset
REQ-024 While reset=1: mem_addr=0, instr_valid=0, instr_out=0, pc_out=0, align_err=0; all inputs ignored.
REQ-025 At the edge reset is sampled high: state<=IDLE, fetch_pc<=0, resp_pc<=0, instr_count<=0, align_err<=0.
REQ-026 Reset asserted mid-stall or mid-redirect discards all pending work; the first fetch after release is address 0.

Verification
REQ-027 Reset, then 4 cycles with stall=0:
  - mem_addr sequence 0,4,8,12.
  - pc_out 0,4,8 with instr_valid=1 from the second cycle.
  - instr_count=3.
REQ-028 stall=1 for 3 cycles while pc_out=8:
  - pc_out stays 8 and mem_addr=8 throughout; instr_out is unchanged.
  - instr_count is frozen.
  - After release, mem_addr=12 and pc_out=12 on the next cycle.
REQ-029 branch_taken=1, target=40, while pc_out=16: that cycle mem_addr=40 and instr_valid=0; next cycle pc_out=40, instr_valid=1, mem_addr=44.
REQ-030 branch_taken=1 with stall=1, target=32: the redirect wins and pc_out=32 on the next cycle.
REQ-031 Target=0x2A: mem_addr=0x28; align_err=1 for exactly one cycle; then pc_out=0x28.
REQ-032 Other checks:
  - Reset asserted during HOLD: mem_addr=0 and instr_valid=0 during reset; instr_count=0 after release.
  - fetch_pc at 2^`WORD-4 wraps to mem_addr=0.
